// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file dump reader.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Address width for an n-entry register file; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a wrap-around address range of the register file and streams each
// word out through a single valid/ready holding register.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int AW   = addr_w(N),
  localparam int CW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CW-1:0]    num_words,
  output logic             busy,
  output logic             done,
  output logic             rf_read_en,
  output logic [AW-1:0]    rf_read_addr,
  input  logic [WIDTH-1:0] rf_data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  state_t        state_q;
  state_t        state_next;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] rem_q;
  logic          slot_free;
  logic          issue;

  assign slot_free    = !m_valid || m_ready;
  assign busy         = (state_q != IDLE);
  assign rf_read_addr = addr_q;

  always_comb begin
    state_next = state_q;
    rf_read_en = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_next = (num_words == '0) ? FINISH : READ;
        end
      end
      READ: begin
        // A read is only issued when the holding register is empty or draining.
        rf_read_en = slot_free;
        issue      = slot_free;
        if (slot_free && rem_q == CW'(1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == IDLE && start) begin
        addr_q <= base_addr;
        rem_q  <= num_words;
      end
      if (issue) begin
        m_data  <= rf_data_in;
        m_valid <= 1'b1;
        m_last  <= (rem_q == CW'(1));
        // Explicit wrap so non-power-of-two N stays in range.
        addr_q  <= (addr_q == AW'(N - 1)) ? '0 : addr_q + AW'(1);
        rem_q   <= rem_q - CW'(1);
      end else if (state_q == DRAIN && m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: scenario tasks plus randomized
// dumps checked against an address/data list computed from a memory array.
module tb_regfile_dump_reader;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       base_addr;
  logic [2:0]       num_words;
  logic             busy;
  logic             done;
  logic             rf_read_en;
  logic [1:0]       rf_read_addr;
  logic [WIDTH-1:0] rf_data_in;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  logic [WIDTH-1:0] mem [N];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign rf_data_in = mem[rf_read_addr];

  regfile_dump_reader #(.WIDTH(WIDTH), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .rf_read_en   (rf_read_en),
    .rf_read_addr (rf_read_addr),
    .rf_data_in   (rf_data_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  task automatic preload();
    for (int i = 0; i < N; i++) mem[i] = 32'hA0 + i;
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 2 cycles on word stall_idx.
  task automatic run_dump(input string tag, input int base, input int num,
                          input int mode, input int stall_idx, input int repulse_cyc,
                          output int first_rd, output int first_vld,
                          output int last_xfer, output int done_cyc);
    logic [WIDTH-1:0] exp_q [$];
    int cyc, reads, xfers, stalls;
    bit done_seen, held;
    logic [WIDTH-1:0] held_data;
    logic held_last;
    exp_q = {};
    for (int k = 0; k < num; k++) exp_q.push_back(mem[(base + k) % N]);
    first_rd = -1; first_vld = -1; last_xfer = -1; done_cyc = -1;
    reads = 0; xfers = 0; stalls = 0; done_seen = 0; held = 0;
    held_data = '0; held_last = 1'b0;

    @(negedge clk);
    start = 1'b1; base_addr = 2'(base); num_words = 3'(num); m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 200) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = !(m_valid && xfers == stall_idx && stalls < 2);
      endcase
      if (cyc == repulse_cyc) begin
        start = 1'b1; base_addr = 2'd2; num_words = 3'd4;
      end else begin
        start = 1'b0;
      end
      #1;
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s busy cyc=%0d got=%b exp=1", tag, cyc, busy);
      end
      if (held) begin
        tests_run++;
        if (m_data !== held_data || m_last !== held_last) begin
          tests_failed++;
          $display("FAIL %s stall_hold cyc=%0d got=%h/%b exp=%h/%b",
                   tag, cyc, m_data, m_last, held_data, held_last);
        end
      end
      held = 0;
      if (rf_read_en === 1'b1) begin
        if (first_rd < 0) first_rd = cyc;
        tests_run++;
        if (reads >= num || rf_read_addr !== 2'((base + reads) % N)) begin
          tests_failed++;
          $display("FAIL %s rd_addr cyc=%0d got=%0d exp=%0d (read %0d of %0d)",
                   tag, cyc, rf_read_addr, (base + reads) % N, reads, num);
        end
        reads++;
      end
      if (m_valid === 1'b1 && m_ready === 1'b0) begin
        tests_run++;
        if (rf_read_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s stall_read cyc=%0d got=%b exp=0", tag, cyc, rf_read_en);
        end
        held = 1; held_data = m_data; held_last = m_last; stalls++;
      end
      if (m_valid === 1'b1) begin
        if (first_vld < 0) first_vld = cyc;
        if (xfers >= num) begin
          tests_run++; tests_failed++;
          $display("FAIL %s extra_valid cyc=%0d got=%h exp=none", tag, cyc, m_data);
        end else if (m_ready) begin
          tests_run++;
          if (m_data !== exp_q[xfers] || m_last !== (xfers == num - 1)) begin
            tests_failed++;
            $display("FAIL %s word%0d cyc=%0d got=%h last=%b exp=%h last=%b",
                     tag, xfers, cyc, m_data, m_last, exp_q[xfers], (xfers == num - 1));
          end
          xfers++;
          last_xfer = cyc;
        end
      end
      if (done === 1'b1) begin
        done_seen = 1; done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b1;
    #1;
    tests_run++;
    if (!done_seen || xfers != num || reads != num) begin
      tests_failed++;
      $display("FAIL %s completion got done=%0d xfers=%0d reads=%0d exp done=1 xfers=%0d reads=%0d",
               tag, done_seen, xfers, reads, num, num);
    end
    tests_run++;
    if (done_cyc != ((num == 0) ? 1 : last_xfer + 1)) begin
      tests_failed++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", tag, done_cyc,
               (num == 0) ? 1 : last_xfer + 1);
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s post_done got busy=%b done=%b exp busy=0 done=0", tag, busy, done);
    end
    $display("[TB] %s base=%0d num=%0d xfers=%0d done_cyc=%0d", tag, base, num, xfers, done_cyc);
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (busy !== 0 || done !== 0 || m_valid !== 0 || m_last !== 0 ||
        m_data !== '0 || rf_read_en !== 0) begin
      tests_failed++;
      $display("FAIL reset got busy=%b done=%b vld=%b last=%b data=%h ren=%b exp all 0",
               busy, done, m_valid, m_last, m_data, rf_read_en);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int fr, fv, lx, dc;
    preload();
    run_dump("basic", 0, 4, 0, 0, -1, fr, fv, lx, dc);
    tests_run++;
    if (fr != 1 || fv != 2 || lx != 5) begin
      tests_failed++;
      $display("FAIL basic_latency got rd=%0d vld=%0d last=%0d exp rd=1 vld=2 last=5", fr, fv, lx);
    end
  endtask

  task automatic test_wrap();
    int fr, fv, lx, dc;
    preload();
    run_dump("wrap", 3, 3, 0, 0, -1, fr, fv, lx, dc);
  endtask

  task automatic test_stall();
    int fr, fv, lx, dc;
    preload();
    run_dump("stall", 0, 4, 2, 1, -1, fr, fv, lx, dc);
    tests_run++;
    if (lx != 7) begin
      tests_failed++;
      $display("FAIL stall_last_xfer got=%0d exp=7", lx);
    end
  endtask

  task automatic test_zero();
    int fr, fv, lx, dc;
    run_dump("zero", 1, 0, 0, 0, -1, fr, fv, lx, dc);
    tests_run++;
    if (fv != -1 || fr != -1) begin
      tests_failed++;
      $display("FAIL zero_no_valid got vld_cyc=%0d rd_cyc=%0d exp=-1", fv, fr);
    end
  endtask

  task automatic test_async_reset();
    int fr, fv, lx, dc, xf, cyc;
    preload();
    @(negedge clk);
    start = 1'b1; base_addr = 2'd0; num_words = 3'd4; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xf = 0; cyc = 0;
    while (xf < 2 && cyc < 20) begin
      #1;
      if (m_valid && m_ready) xf++;
      if (xf < 2) @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (xf != 2) begin
      tests_failed++;
      $display("FAIL abort_progress got=%0d exp=2", xf);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (m_valid !== 0 || busy !== 0 || rf_read_en !== 0 || done !== 0) begin
      tests_failed++;
      $display("FAIL abort_async got vld=%b busy=%b ren=%b done=%b exp 0",
               m_valid, busy, rf_read_en, done);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 0 || busy !== 0) begin
      tests_failed++;
      $display("FAIL abort_hold got done=%b busy=%b exp 0", done, busy);
    end
    rst = 1'b0;
    run_dump("after_abort", 0, 4, 0, 0, -1, fr, fv, lx, dc);
  endtask

  task automatic test_start_while_busy();
    int fr, fv, lx, dc;
    preload();
    run_dump("repulse", 0, 4, 0, 0, 2, fr, fv, lx, dc);
  endtask

  task automatic test_random();
    int fr, fv, lx, dc;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      run_dump("random", $urandom_range(0, N - 1), $urandom_range(0, 7), 1, 0,
               (it % 3 == 0) ? 3 : -1, fr, fv, lx, dc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; m_ready = 1'b1;
    preload();
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero();
    test_async_reset();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
